// File: rtl/program_dumper_pkg.sv
// Shared core types for the program dumper: sequencer and serial
// transmitter state encodings, default bit timing and small helpers
// for word/byte addressing.
package program_dumper_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    // Width of the word index and captured word count
    localparam int unsigned WORD_IDX_W = 16;

    // Bytes carried per program word
    localparam int unsigned BYTES_PER_WORD = 4;

    // Dump sequencer states
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        FINISH
    } dump_state_t;

    // Serial transmitter states
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Byte address of program word idx; the upper bits stay zero so the
    // full 16-bit index range never wraps.
    function automatic logic [31:0] word_addr(input logic [WORD_IDX_W-1:0] idx);
        return {14'b0, idx, 2'b00};
    endfunction

    // Little-endian byte sel of a 32-bit word
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/program_dumper_tx.sv
// 8N1 UART transmitter. Accepts a byte when idle and start is high,
// then drives start bit, eight data bits LSB first and a stop bit, each
// CLKS_PER_BIT cycles long. busy is high exactly while a frame is on
// the line; the line idles high.
module uart_transmitter
    import program_dumper_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       TX
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (clk_cnt == BIT_LAST);

    // Frame sequencer: bit timing, shifting and line drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            TX      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    clk_cnt <= '0;
                    TX      <= 1'b1;
                    if (start) begin
                        shreg <= data;
                        TX    <= 1'b0;
                        busy  <= 1'b1;
                        state <= TX_START;
                    end
                end

                TX_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        TX      <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                TX_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            TX    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            // shreg[0] is the bit now on the line, so the next one is shreg[1]
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            TX      <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                TX_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= TX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= TX_IDLE;
                    busy  <= 1'b0;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/program_dumper.sv
// Program memory dumper. On a rising start edge, reads count 32-bit
// words from program memory (word i at byte address 4*i) and sends each
// word over the UART as four bytes, least significant byte first.
// The next word is fetched while the previous word's last byte is still
// on the line, so frames within a dump are separated by at most two
// idle cycles.
module program_dumper
    import program_dumper_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] count,
    output logic [31:0] pmemaddr,
    output logic        pmemre,
    input  logic [31:0] pmemdata,
    output logic        RsTx,
    output logic        busy,
    output logic        done
);

    dump_state_t           state;
    logic                  start_q;
    logic                  armed;
    logic                  start_edge;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [WORD_IDX_W-1:0] word_cnt;
    logic [31:0]           word;
    logic [1:0]            byte_idx;
    logic                  draining;
    logic                  last_word;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;

    // armed stays low after reset until start has been seen low, so a
    // start held high through reset release cannot fake a rising edge.
    assign start_edge = start & ~start_q & armed;

    // Widened compare so index+1 cannot wrap against count=65535
    assign last_word = ({1'b0, word_idx} + 17'd1) == {1'b0, word_cnt};

    // Start input sampling for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= start;
            if (!start) begin
                armed <= 1'b1;
            end
        end
    end

    // Dump sequencer: word fetch, byte issue to the transmitter, completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pmemaddr <= '0;
            pmemre   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_idx <= '0;
            word_cnt <= '0;
            word     <= '0;
            byte_idx <= '0;
            draining <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        if (count != '0) begin
                            busy     <= 1'b1;
                            word_idx <= '0;
                            word_cnt <= count;
                            pmemaddr <= word_addr('0);
                            pmemre   <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end

                FETCH: begin
                    pmemre <= 1'b0;
                    state  <= LATCH;
                end

                LATCH: begin
                    word     <= pmemdata;
                    byte_idx <= '0;
                    draining <= 1'b0;
                    // First word finds the transmitter idle: issue byte 0
                    // straight from the memory bus to save a cycle.
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= pmemdata[7:0];
                    end
                    state <= SEND;
                end

                SEND: begin
                    if (tx_start) begin
                        // Transmitter took the byte this cycle
                        tx_start <= 1'b0;
                        if (byte_idx == 2'd3) begin
                            if (last_word) begin
                                draining <= 1'b1;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                                pmemaddr <= word_addr(word_idx + 1'b1);
                                pmemre   <= 1'b1;
                                state    <= FETCH;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (draining) begin
                        if (!tx_busy) begin
                            draining <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= word_byte(word, byte_idx);
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    pmemre   <= 1'b0;
                    busy     <= 1'b0;
                    tx_start <= 1'b0;
                    draining <= 1'b0;
                end
            endcase
        end
    end

    uart_transmitter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .start (tx_start),
        .busy  (tx_busy),
        .TX    (RsTx)
    );

endmodule

// File: tb/tb_program_dumper.sv
// Self-checking bench for program_dumper with a fast bit rate.
module tb_program_dumper;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic [31:0] pmemaddr;
    logic        pmemre;
    logic [31:0] pmemdata = '0;
    logic        RsTx;
    logic        busy;
    logic        done;

    program_dumper #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (rst),
        .start    (start),
        .count    (count),
        .pmemaddr (pmemaddr),
        .pmemre   (pmemre),
        .pmemdata (pmemdata),
        .RsTx     (RsTx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Program memory: data valid the cycle after the read strobe
    logic [31:0] mem [16];
    always @(posedge clk) if (pmemre) pmemdata <= mem[pmemaddr[5:2]];

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    // Observers: UART receiver, read strobes, done pulses, busy time
    logic [7:0]  rx_q[$];
    int unsigned frame_starts[$];
    logic [31:0] addr_q[$];
    int          done_cnt = 0;
    int          busy_cycles = 0;
    int          frame_errs = 0;
    bit          rx_active = 0;
    int unsigned rx_cnt = 0;
    logic [7:0]  rx_byte = '0;

    always @(negedge clk) begin
        int unsigned k;
        if (pmemre) addr_q.push_back(pmemaddr);
        if (done) done_cnt++;
        if (busy) busy_cycles++;
        if (rst) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (RsTx === 1'b0) begin
                rx_active = 1;
                rx_cnt = 0;
                frame_starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                k = rx_cnt / CPB;
                if (k == 0) begin
                    if (RsTx !== 1'b0) frame_errs++;
                end else if (k <= 8) begin
                    rx_byte[k-1] = RsTx;
                end else begin
                    if (RsTx !== 1'b1) frame_errs++;
                    rx_q.push_back(rx_byte);
                end
            end
            if (rx_cnt == FRAME - 1) rx_active = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input longint act, input longint lim);
        checks++;
        if (act > lim) begin
            failures++;
            $display("FAIL %s: actual=%0d required<=%0d", name, act, lim);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        frame_starts.delete();
        addr_q.delete();
        done_cnt = 0;
        busy_cycles = 0;
        frame_errs = 0;
    endtask

    // Runs one dump of n words from mem[] and compares everything observed
    // against the byte/address stream the memory contents imply.
    task automatic run_dump(input logic [15:0] n, input int busy_max, input int retrig,
                            input int hold, input bit jitter, input string tag);
        logic [7:0]  exp_b[$];
        logic [31:0] exp_a[$];
        int          limit;
        int          elapsed;
        int          rst_state;
        int          maxgap;
        int          gap;
        bit          got;
        clear_mon();
        for (int i = 0; i < int'(n); i++) begin
            exp_a.push_back(32'(4 * i));
            for (int b = 0; b < 4; b++) exp_b.push_back(mem[i][8*b +: 8]);
        end
        count = n;
        @(negedge clk);
        start = 1'b1;
        limit = int'(n) * 4 * (int'(FRAME) + 3) + 60;
        got = 0;
        elapsed = 0;
        rst_state = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            #1;
            elapsed = c + 1;
            if (c + 1 >= hold) start = 1'b0;
            if (rst_state == 1) begin
                start = 1'b0;
                rst_state = 2;
            end else if (rst_state == 0 && retrig >= 0 && rx_q.size() == retrig) begin
                start = 1'b1;
                rst_state = 1;
            end
            if (done_cnt != 0) begin
                got = 1;
                break;
            end
            if (jitter && busy) begin
                start = 1'($urandom_range(0, 1));
                count = 16'($urandom);
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(got), 64'd1);
        repeat (2 * FRAME) @(negedge clk);
        #1;
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " byte_count"}, 64'(rx_q.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_b[i]));
        check({tag, " read_count"}, 64'(addr_q.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
            check($sformatf("%s addr%0d", tag, i), 64'(addr_q[i]), 64'(exp_a[i]));
        check({tag, " framing_errors"}, 64'(frame_errs), 64'd0);
        check_le({tag, " busy_cycles"}, busy_cycles, busy_max);
        maxgap = 0;
        for (int k = 1; k < frame_starts.size(); k++) begin
            gap = int'(frame_starts[k] - frame_starts[k-1]) - int'(FRAME);
            if (gap > maxgap) maxgap = gap;
        end
        if (frame_starts.size() > 1) check_le({tag, " frame_gap"}, maxgap, 2);
        if (n == 0) begin
            check_le({tag, " done_latency"}, elapsed, 3);
            check({tag, " no_frames"}, 64'(frame_starts.size()), 64'd0);
        end else begin
            check({tag, " addr_hold"}, 64'(pmemaddr), 64'(exp_a[exp_a.size()-1]));
        end
        check({tag, " idle_line"}, 64'(RsTx), 64'd1);
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [15:0]      n;
        logic [2:0][31:0] w;
        int               busy_max;
        int               retrig;
        int               hold;
        string            name;
    } vec_t;

    function automatic int busy_bound(input int n);
        return n * 4 * int'(FRAME) + (n * 4 - 1) * 2 + 10;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   found;
        vecs[0] = '{16'd1, {32'h0, 32'h0, 32'h44332211}, 4 * 40 + 10, -1, 1, "one_word"};
        vecs[1] = '{16'd3, {32'h12345678, 32'h0000FFFF, 32'hA0A0A0A0}, busy_bound(3), -1, 1, "three_words"};
        vecs[2] = '{16'd0, {32'h0, 32'h0, 32'h0}, 2, -1, 1, "zero_count"};
        vecs[3] = '{16'd2, {32'h0, 32'h89ABCDEF, 32'h01234567}, busy_bound(2), 2, 1, "retrigger"};
        vecs[4] = '{16'd1, {32'h0, 32'h0, 32'hDEADBEEF}, 4 * 40 + 10, -1, 100, "held_start"};

        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset RsTx", 64'(RsTx), 64'd1);
        check("reset pmemre", 64'(pmemre), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset pmemaddr", 64'(pmemaddr), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 3; i++) mem[i] = vecs[v].w[i];
            run_dump(vecs[v].n, vecs[v].busy_max, vecs[v].retrig, vecs[v].hold, 1'b0, vecs[v].name);
        end

        // Reset in the middle of the data bits of byte 1
        mem[0] = 32'hCAFEF00D;
        clear_mon();
        count = 16'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (rx_q.size() == 1 && rx_active && rx_cnt == 2 * CPB + 2) begin
                found = 1;
                break;
            end
        end
        check("midreset reached_byte1", 64'(found), 64'd1);
        rst = 1'b1;
        start = 1'b1;
        #1;
        check("midreset RsTx", 64'(RsTx), 64'd1);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset pmemre", 64'(pmemre), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (30) @(negedge clk);
        #1;
        check("held_after_reset busy", 64'(busy_cycles), 64'd0);
        check("held_after_reset reads", 64'(addr_q.size()), 64'd0);
        check("held_after_reset frames", 64'(frame_starts.size()), 64'd0);
        start = 1'b0;
        run_dump(16'd1, 4 * 40 + 10, -1, 1, 1'b0, "after_reset");

        // Randomised dumps, with start/count disturbed while busy on odd runs
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) mem[i] = $urandom;
            run_dump(16'(n), busy_bound(n), -1, 1, 1'(it % 2), $sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_dumper.md
PROGRAM_DUMPER -- requirements
Module: program_dumper

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  synchronous request; a 0->1 transition begins a dump.
REQ-005 count  input  16  number of 32-bit words to dump, sampled on the accepted start edge.
REQ-006 pmemaddr  output  32  byte address into program memory; word i at address 4*i.
REQ-007 pmemre  output  1  read strobe, high for exactly one cycle per word.
REQ-008 pmemdata  input  32  read data, valid the cycle after pmemre is high.
REQ-009 RsTx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-010 busy  output  1  high from accepted start until the last stop bit completes.
REQ-011 done  output  1  one-cycle pulse when a dump finishes.

Function
REQ-012 Start edge: start is registered each cycle; an edge is start=1 with the previous registered sample 0; edges while busy=1 are ignored.
REQ-013 States: IDLE, FETCH, LATCH, SEND, FINISH.
REQ-014 IDLE: on an edge with count!=0 -> FETCH, busy=1, word index=0, count captured; with count==0 -> FINISH.
REQ-015 FETCH (1 cycle): pmemaddr=4*index, pmemre=1 -> LATCH.
REQ-016 LATCH (1 cycle): pmemdata captured into word register, byte index=0 -> SEND.
REQ-017 SEND: bytes sent in order word[7:0], [15:8], [23:16], [31:24] via the TX sub-module's start/busy handshake; a new byte is issued only when the sub-module is idle.
REQ-018 After byte 3 is accepted: index+1==count -> FINISH once the sub-module goes idle; otherwise index increments -> FETCH (the fetch overlaps the byte-3 frame).
REQ-019 FINISH (1 cycle): done=1, busy=0 -> IDLE.
REQ-020 Frame: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-021 Inter-frame gap: at most 2 idle-high cycles between one stop bit ending and the next start bit within a dump.
REQ-022 Word index and captured count are 16-bit; pmemaddr = {14'b0, index, 2'b00}; count=65535 covers addresses 0..262136 without wrap.
REQ-023 pmemaddr holds its last value when pmemre=0; pmemre is never high outside FETCH.
REQ-024 Changes on count or start while busy have no effect on the running dump.

Reset
REQ-025 reset=1 immediately forces: state IDLE, RsTx=1, pmemre=0, busy=0, done=0, pmemaddr=0, all counters and the start edge register 0.
REQ-026 Reset mid-frame aborts the frame without completing it; after reset release, a held-high start produces no edge until it returns low and rises again.

Structure
REQ-027 State enum and the default CLKS_PER_BIT constant live in a shared core package alongside the other serial/loader types.
REQ-028 One sub-module, uart_transmitter (clk, reset, data[7:0], start, busy, TX), owns bit timing; program_dumper owns sequencing and memory access.

Verification (CLKS_PER_BIT=4 for simulation)
REQ-029 count=1, mem[0]=0x44332211, start pulse -> RsTx bytes 0x11,0x22,0x33,0x44; pmemre once with pmemaddr=0; done pulse once; busy high for at most 4*40+10 cycles.
REQ-030 count=3, mem=0xA0A0A0A0/0x0000FFFF/0x12345678 -> 12 bytes in little-endian word order; pmemaddr sequence 0,4,8; gaps between frames of at most 2 cycles.
REQ-031 count=0, start pulse -> done pulse within 3 cycles, RsTx stays 1, pmemre never asserted.
REQ-032 Second start edge during byte 2 of a count=2 dump -> ignored; exactly 8 bytes sent, one done pulse.
REQ-033 reset asserted in the middle of the data bits of byte 1 -> RsTx=1 and busy=0 in the same cycle; start held high through release -> no dump until start falls and rises again.
REQ-034 start held high for 100 cycles with count=1 -> exactly one dump (4 bytes, one done pulse).
